muldiv_iter_unit: RTL and testbench

Iterative RV32M multiply/divide engine, parametrised in datapath width and bits retired per cycle. It sits beside the single-cycle ALU in the execute stage. It accepts one operation at a time from the decoded EX instruction and holds the pipeline through `busy` until it returns a tagged result for write-back. Division is a compile-time option.

---
 rtl/muldiv_iter_unit_pkg.sv | 26 ++
 rtl/muldiv_iter_unit_step.sv | 49 ++++
 rtl/muldiv_iter_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_iter_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_iter_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, FSM state type and the most-negative constant helper.
package muldiv_iter_unit_pkg;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FIXUP = 2'd2,
    ST_DONE  = 2'd3
  } md_state_t;

  // Returns 2^(xlen-1); callers truncate to their own width (xlen <= 64).
  function automatic logic [63:0] most_neg(input int unsigned xlen);
    return 64'd1 << (xlen - 1);
  endfunction

endpackage

// File: rtl/muldiv_iter_unit_step.sv
// One CALC iteration: BITS_PER_CYCLE shift-add (multiply) or restoring
// shift-subtract (divide) steps on the {hi, lo} accumulator.
// Divide steps exist only when MULDIV_DIV_EN is defined.
module muldiv_step #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   opnd,
`ifdef MULDIV_DIV_EN
  input  logic              is_div,
`endif
  output logic [2*XLEN-1:0] acc_next
);

  // Multiply: lo holds the multiplier, hi accumulates; shift right each bit.
  function automatic logic [2*XLEN-1:0] mul_bit(input logic [2*XLEN-1:0] a,
                                                input logic [XLEN-1:0]   m);
    logic [XLEN:0] sum;
    sum = {1'b0, a[2*XLEN-1:XLEN]} + (a[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
    return {sum, a[XLEN-1:1]};
  endfunction

`ifdef MULDIV_DIV_EN
  // Divide: hi holds the partial remainder, lo shifts dividend out / quotient in.
  function automatic logic [2*XLEN-1:0] div_bit(input logic [2*XLEN-1:0] a,
                                                input logic [XLEN-1:0]   d);
    logic [XLEN:0] rem_sh;
    logic [XLEN:0] diff;
    rem_sh = {a[2*XLEN-1:XLEN], a[XLEN-1]};
    diff   = rem_sh - {1'b0, d};
    if (diff[XLEN])
      return {rem_sh[XLEN-1:0], a[XLEN-2:0], 1'b0};
    return {diff[XLEN-1:0], a[XLEN-2:0], 1'b1};
  endfunction
`endif

  always_comb begin
    acc_next = acc;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
`ifdef MULDIV_DIV_EN
      acc_next = is_div ? div_bit(acc_next, opnd) : mul_bit(acc_next, opnd);
`else
      acc_next = mul_bit(acc_next, opnd);
`endif
    end
  end

endmodule

// File: rtl/muldiv_iter_unit.sv
// Iterative RV32M multiply/divide engine with tagged write-back result.
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops return
// result 0 with op_err on the 1-cycle path.
module muldiv_iter_unit
  import muldiv_iter_unit_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_tag,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      result_tag,
  output logic            op_err
);

  localparam int unsigned N  = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CW = $clog2(N) + 1;

  md_state_t         state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, acc_step;
  logic [XLEN-1:0]   opnd;
  logic [2:0]        op;
  logic [4:0]        tag;
  logic              neg;

  logic              a_signed, b_signed, sa, sb, special;
  logic [XLEN-1:0]   a_mag, b_mag, special_val, fix_val;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    a_signed = funct3 inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    b_signed = funct3 inside {MD_MULH, MD_DIV, MD_REM};
    sa       = a_signed & rs1_val[XLEN-1];
    sb       = b_signed & rs2_val[XLEN-1];
    a_mag    = sa ? -rs1_val : rs1_val;
    b_mag    = sb ? -rs2_val : rs2_val;
  end

`ifdef MULDIV_DIV_EN
  localparam logic [XLEN-1:0] MOST_NEG = XLEN'(most_neg(XLEN));

  always_comb begin
    special     = 1'b0;
    special_val = '0;
    if (funct3[2]) begin
      if (rs2_val == '0) begin
        special     = 1'b1;
        special_val = funct3[1] ? rs1_val : '1;
      end else if (!funct3[0] && rs1_val == MOST_NEG && rs2_val == '1) begin
        special     = 1'b1;
        special_val = funct3[1] ? '0 : MOST_NEG;
      end
    end
  end

  assign op_err = 1'b0;
`else
  always_comb begin
    special     = funct3[2];
    special_val = '0;
  end
`endif

  // Divide negation is done per half: the high half of -acc is not -remainder.
  always_comb begin
    prod    = neg ? -acc : acc;
    fix_val = '0;
    case (op)
      MD_MUL:                       fix_val = prod[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_val = prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      MD_DIV, MD_DIVU:              fix_val = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      MD_REM, MD_REMU:              fix_val = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
`endif
      default:                      fix_val = '0;
    endcase
  end

  muldiv_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .acc      (acc),
    .opnd     (opnd),
`ifdef MULDIV_DIV_EN
    .is_div   (op[2]),
`endif
    .acc_next (acc_step)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = special ? ST_DONE : ST_CALC;
        ST_CALC:  if (cnt == CW'(N - 1)) state_nxt = ST_FIXUP;
        ST_FIXUP: state_nxt = ST_DONE;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // Result registers are written on the edge entering DONE so they are valid with done.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= '0;
      acc        <= '0;
      opnd       <= '0;
      op         <= '0;
      tag        <= '0;
      neg        <= 1'b0;
      result     <= '0;
      result_tag <= '0;
`ifndef MULDIV_DIV_EN
      op_err     <= 1'b0;
`endif
    end else if (!flush) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op  <= funct3;
            tag <= rd_tag;
            cnt <= '0;
            neg <= (funct3[2] && funct3[1]) ? sa : (sa ^ sb);
            if (funct3[2]) begin
              acc  <= {{XLEN{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{XLEN{1'b0}}, b_mag};
              opnd <= a_mag;
            end
            if (special) begin
              result     <= special_val;
              result_tag <= rd_tag;
`ifndef MULDIV_DIV_EN
              op_err     <= 1'b1;
`endif
            end
          end
        end
        ST_CALC: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
        end
        ST_FIXUP: begin
          result     <= fix_val;
          result_tag <= tag;
`ifndef MULDIV_DIV_EN
          op_err     <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Scoreboard bench for muldiv_iter_unit: a radix-2 instance and a radix-16
// instance; expectations adapt to whether MULDIV_DIV_EN is defined.
module tb_muldiv_iter_unit;
  import muldiv_iter_unit_pkg::*;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0, flush0, start1, flush1;
  logic [2:0]  f3_0, f3_1;
  logic [31:0] a0, b0, a1, b1;
  logic [4:0]  tag0, tag1;
  logic        busy0, done0, err0, busy1, done1, err1;
  logic [31:0] res0, res1;
  logic [4:0]  rtag0, rtag1;

  muldiv_iter_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .start(start0), .funct3(f3_0), .rs1_val(a0), .rs2_val(b0),
    .rd_tag(tag0), .flush(flush0), .busy(busy0), .done(done0), .result(res0),
    .result_tag(rtag0), .op_err(err0)
  );

  muldiv_iter_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .start(start1), .funct3(f3_1), .rs1_val(a1), .rs2_val(b1),
    .rd_tag(tag1), .flush(flush1), .busy(busy1), .done(done1), .result(res1),
    .result_tag(rtag1), .op_err(err1)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        err;
    int          lat;
    int          issue;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] last_res0 = '0;
  logic [4:0]  last_tag0 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (done0 === 1'b1) begin
      if (q0.size() == 0) begin
        chk("dut spurious done", 32'(done0), 32'd0);
      end else begin
        e = q0.pop_front();
        chk("dut result", res0, e.res);
        chk("dut result_tag", 32'(rtag0), 32'(e.tag));
        chk("dut op_err", 32'(err0), 32'(e.err));
        chk("dut latency", 32'(cyc - e.issue), 32'(e.lat));
        last_res0 = e.res;
        last_tag0 = e.tag;
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        chk("dut4 spurious done", 32'(done1), 32'd0);
      end else begin
        e = q1.pop_front();
        chk("dut4 result", res1, e.res);
        chk("dut4 result_tag", 32'(rtag1), 32'(e.tag));
        chk("dut4 op_err", 32'(err1), 32'(e.err));
        chk("dut4 latency", 32'(cyc - e.issue), 32'(e.lat));
      end
    end
  end

  task automatic drain(input int sel);
    for (int k = 0; k < 100; k++) begin
      if ((sel == 0 ? q0.size() : q1.size()) == 0) break;
      @(posedge clk);
      #2;
    end
    if ((sel == 0 ? q0.size() : q1.size()) != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL dut%0d done timeout: %0d results outstanding, expected 0", sel,
               (sel == 0 ? q0.size() : q1.size()));
      if (sel == 0) q0.delete(); else q1.delete();
    end
  endtask

  task automatic issue(input int sel, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input logic [31:0] er,
                       input logic ee, input int lat, input bit wait_done);
    exp_t e;
    @(negedge clk);
    e.res = er; e.tag = tag; e.err = ee; e.lat = lat; e.issue = cyc;
    if (sel == 0) begin
      start0 = 1'b1; f3_0 = f3; a0 = a; b0 = b; tag0 = tag; q0.push_back(e);
    end else begin
      start1 = 1'b1; f3_1 = f3; a1 = a; b1 = b; tag1 = tag; q1.push_back(e);
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    if (wait_done) drain(sel);
  endtask

  // Divide ops: with the divider compiled out they all take the 1-cycle error path.
  task automatic issue_div(input int sel, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag,
                           input logic [31:0] er, input int lat);
    if (DIV_EN) issue(sel, f3, a, b, tag, er, 1'b0, lat, 1'b1);
    else        issue(sel, f3, a, b, tag, 32'd0, 1'b1, 1, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    start0 = 1'b0; flush0 = 1'b0; f3_0 = '0; a0 = '0; b0 = '0; tag0 = '0;
    start1 = 1'b0; flush1 = 1'b0; f3_1 = '0; a1 = '0; b1 = '0; tag1 = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy0), 32'd0);
    chk("reset done", 32'(done0), 32'd0);
    chk("reset result", res0, 32'd0);
    chk("reset result_tag", 32'(rtag0), 32'd0);
    chk("reset op_err", 32'(err0), 32'd0);
    chk("reset busy dut4", 32'(busy1), 32'd0);
    rst = 1'b1;

    // Multiply, radix 2
    issue(0, MD_MUL,    32'd7,          32'd6,          5'd5,  32'd42,         1'b0, 34, 1'b1);
    issue(0, MD_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1,  32'h4000_0000, 1'b0, 34, 1'b1);
    issue(0, MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF, 1'b0, 34, 1'b1);
    issue(0, MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 1'b0, 34, 1'b1);
    issue(0, MD_MUL,    32'hFFFF_FFFD, 32'd5,          5'd4,  32'hFFFF_FFF1, 1'b0, 34, 1'b1);
    issue(0, MD_MULH,   32'hFFFF_FFFE, 32'd3,          5'd6,  32'hFFFF_FFFF, 1'b0, 34, 1'b1);
    issue(0, MD_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd7,  32'h3FFF_FFFF, 1'b0, 34, 1'b1);
    issue(0, MD_MUL,    32'd3,          32'd3,          5'd8,  32'd9,          1'b0, 34, 1'b1);

    // Divide, radix 2
    issue_div(0, MD_DIV,  32'hFFFF_FFF9, 32'd2,          5'd10, 32'hFFFF_FFFD, 34);
    issue_div(0, MD_REM,  32'hFFFF_FFF9, 32'd2,          5'd11, 32'hFFFF_FFFF, 34);
    issue_div(0, MD_DIV,  32'd7,          32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, 34);
    issue_div(0, MD_REM,  32'd7,          32'hFFFF_FFFE, 5'd13, 32'd1,          34);
    issue_div(0, MD_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 5'd14, 32'h0FFF_FFFF, 34);
    issue_div(0, MD_REMU, 32'hFFFF_FFFF, 32'h0000_0010, 5'd15, 32'h0000_000F, 34);
    issue_div(0, MD_DIV,  32'd9,          32'd3,          5'd16, 32'd3,          34);
    issue_div(0, MD_DIVU, 32'd5,          32'd0,          5'd17, 32'hFFFF_FFFF, 1);
    issue_div(0, MD_REMU, 32'd5,          32'd0,          5'd18, 32'd5,          1);
    issue_div(0, MD_REM,  32'hFFFF_FFF9, 32'd0,          5'd19, 32'hFFFF_FFF9, 1);
    issue_div(0, MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000, 1);
    issue_div(0, MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'd0,          1);
    issue_div(0, MD_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'd0,          34);
    issue_div(0, MD_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'h8000_0000, 34);

    // Radix 16 instance
    issue(1, MD_MUL,    32'd7,          32'd6,          5'd5,  32'd42,         1'b0, 10, 1'b1);
    issue(1, MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 1'b0, 10, 1'b1);
    issue(1, MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF, 1'b0, 10, 1'b1);
    issue_div(1, MD_DIV, 32'hFFFF_FFF9, 32'd2,          5'd10, 32'hFFFF_FFFD, 10);
    issue_div(1, MD_REM, 32'hFFFF_FFF9, 32'd2,          5'd11, 32'hFFFF_FFFF, 10);

    // start while busy is ignored: the in-flight op completes untouched
    issue(0, MD_MUL, 32'd11, 32'd13, 5'd9, 32'd143, 1'b0, 34, 1'b0);
    repeat (5) @(negedge clk);
    chk("busy during CALC", 32'(busy0), 32'd1);
    start0 = 1'b1; f3_0 = MD_MULHU; a0 = 32'hFFFF_FFFF; b0 = 32'hFFFF_FFFF; tag0 = 5'd30;
    @(negedge clk);
    start0 = 1'b0;
    drain(0);
    repeat (40) @(negedge clk);

    // flush mid-CALC: no done, result/tag keep prior values
    @(negedge clk);
    start0 = 1'b1; f3_0 = MD_MUL; a0 = 32'd100; b0 = 32'd200; tag0 = 5'd25;
    @(negedge clk);
    start0 = 1'b0;
    repeat (9) @(negedge clk);
    flush0 = 1'b1;
    @(negedge clk);
    flush0 = 1'b0;
    chk("flush busy", 32'(busy0), 32'd0);
    chk("flush result held", res0, last_res0);
    chk("flush result_tag held", 32'(rtag0), 32'(last_tag0));
    repeat (40) @(negedge clk);

    // flush and start in the same IDLE cycle: nothing captured
    start0 = 1'b1; flush0 = 1'b1; f3_0 = MD_MUL; a0 = 32'd2; b0 = 32'd2; tag0 = 5'd26;
    @(negedge clk);
    start0 = 1'b0; flush0 = 1'b0;
    chk("flush+start busy", 32'(busy0), 32'd0);
    repeat (40) @(negedge clk);

    // reset mid-CALC
    @(negedge clk);
    start0 = 1'b1; f3_0 = MD_MULHU; a0 = 32'd1234; b0 = 32'd5678; tag0 = 5'd27;
    @(negedge clk);
    start0 = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid reset busy", 32'(busy0), 32'd0);
    chk("mid reset done", 32'(done0), 32'd0);
    chk("mid reset result", res0, 32'd0);
    chk("mid reset result_tag", 32'(rtag0), 32'd0);
    chk("mid reset op_err", 32'(err0), 32'd0);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    // operation after reset still correct
    issue(0, MD_MUL, 32'd3, 32'd3, 5'd1, 32'd9, 1'b0, 34, 1'b1);

    drain(0);
    drain(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
